plic_claim_agent: RTL
=====================

Name: plic_claim_agent

Overview:
- Hardware interrupt responder that sits on the initiator side of the PLIC register interface, in place of software.
- When the PLIC asserts its external-interrupt notification, the agent:
  - reads the claim register to obtain the source ID;
  - dispatches the ID to an accelerator/handler over a valid/ready channel;
  - waits for the handler's done indication;
  - writes the ID back to the claim register to complete the interrupt.
- Also enforces a handler timeout and counts spurious (ID 0) claims.

Parameters:
- NumSrc, 32, number of PLIC sources (1..32).
- IdW, $clog2(NumSrc)+1, width of the interrupt ID; ID 0 means no interrupt.
- BaseAddr, 32'h0, PLIC base address; claim/complete register is at BaseAddr+32'h200004.
- CooldownCyc, 3, idle cycles after completion before a new notification is sampled (minimum 2; the PLIC needs 2 cycles to propagate pending state).
- TimeoutCyc, 1024, cycles allowed in WAIT_DONE before a forced completion (minimum 1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active high
- enable_i  in  1  agent enable; when low, no new claim starts
- irq_external_i  in  1  PLIC notification
- reg_en_o  out  1  register access request
- reg_we_o  out  1  1 = write, 0 = read
- reg_addr_o  out  32  access address
- reg_wdata_o  out  32  write data
- reg_rdata_i  in  32  read data, valid the cycle after an accepted read
- reg_ready_i  in  1  access accepted when reg_en_o & reg_ready_i
- evt_valid_o  out  1  dispatch valid
- evt_id_o  out  IdW  dispatched source ID
- evt_ready_i  in  1  handler accepts the dispatch
- done_valid_i  in  1  handler finished
- done_id_i  in  IdW  ID the handler finished
- busy_o  out  1  state != IDLE
- timeout_o  out  1  sticky: a timeout occurred
- mismatch_o  out  1  one-cycle pulse: done_id_i != current ID
- spurious_cnt_o  out  16  saturating count of ID-0 claims
- clr_err_i  in  1  clears timeout_o and spurious_cnt_o

Behaviour:
- Single clock. Reset is synchronous and active-high (rst_i sampled on posedge clk_i).
- Reset values:
  - state = IDLE.
  - All reg_* outputs 0, evt_valid_o 0, evt_id_o 0.
  - busy_o 0, timeout_o 0, mismatch_o 0, spurious_cnt_o 0.
- Reset mid-operation returns to IDLE immediately. No completion is issued; PLIC recovery is the system's responsibility.
- reg_addr_o is always BaseAddr+32'h200004 while reg_en_o is high, and 0 otherwise.
- States and transitions:
  - IDLE:
    - If enable_i & irq_external_i, go to CLAIM_REQ on the next cycle.
  - CLAIM_REQ:
    - Drive reg_en_o=1, reg_we_o=0; hold until reg_ready_i.
    - On the accept cycle, go to CLAIM_RSP.
  - CLAIM_RSP:
    - Capture id = reg_rdata_i[IdW-1:0]; upper bits are ignored.
    - If id == 0: increment spurious_cnt_o (saturates at 16'hFFFF) and go to COOLDOWN (no completion is written).
    - Else if id > NumSrc: treat as spurious.
    - Else go to DISPATCH.
  - DISPATCH:
    - evt_valid_o=1 and evt_id_o=id, both stable until evt_ready_i.
    - On accept, go to WAIT_DONE and clear the timeout counter.
  - WAIT_DONE:
    - Timeout counter increments every cycle.
    - done_valid_i & done_id_i == id: go to COMPL_REQ.
    - done_valid_i & mismatch: pulse mismatch_o for one cycle and stay.
    - Counter reaches TimeoutCyc-1 with no matching done: set timeout_o and go to COMPL_REQ.
    - A matching done in the same cycle as timeout expiry wins (timeout_o is not set).
  - COMPL_REQ:
    - Drive reg_en_o=1, reg_we_o=1, reg_wdata_o = zero-extended id; hold until reg_ready_i.
    - Then go to COOLDOWN.
  - COOLDOWN:
    - Count CooldownCyc cycles, then go to IDLE.
    - irq_external_i is ignored throughout.
- enable_i deasserting only blocks IDLE→CLAIM_REQ. An in-flight transaction always runs to completion.
- clr_err_i in the same cycle as a spurious increment or timeout set: the clear wins.
- Latency with reg_ready_i=1, evt_ready_i=1 and immediate done:
  - irq_external_i at cycle 0 → claim read at cycle 1.
  - evt_valid_o at cycle 3.
  - completion write one cycle after done_valid_i.
- Handshake outputs are registered. No combinational path from inputs to reg_* or evt_* outputs.

Decomposition:
- Package plic_agent_pkg:
  - state enum (IDLE, CLAIM_REQ, CLAIM_RSP, DISPATCH, WAIT_DONE, COMPL_REQ, COOLDOWN);
  - localparam ClaimOffset = 32'h200004.
- One sub-module, plic_agent_timer: loadable down-counter shared by the cooldown and timeout functions, with load, enable and expire ports.

Test Plan:
- Basic flow: PLIC model with source 5 pending; irq_external_i=1, ready always 1, handler done 4 cycles after dispatch.
  - Read at cycle 1; evt_id_o=5 at cycle 3; write data 32'h5; busy_o low after cooldown.
- Spurious claim: irq_external_i=1 with claim read returning 0.
  - No dispatch, no write; spurious_cnt_o=1; back in IDLE after CooldownCyc.
- Backpressure: reg_ready_i low for 3 cycles in both CLAIM_REQ and COMPL_REQ; evt_ready_i low for 5 cycles.
  - Outputs held stable; exactly one read and one write accepted; evt_id_o stable.
- Timeout: TimeoutCyc=16, handler never responds.
  - Completion write with id at WAIT_DONE+16; timeout_o=1; clr_err_i clears it.
- Mismatch: id 7 in flight; done_id_i=3, then 7.
  - mismatch_o pulses once; completion carries 7.
- Reset mid-DISPATCH, and enable_i=0: rst_i during DISPATCH.
  - All outputs return to reset values the next cycle.
  - With enable_i=0 and irq_external_i=1, no access occurs.

Source files
------------

// File: rtl/plic_agent_pkg.sv
// Shared types and constants for the PLIC claim/complete agent.
package plic_agent_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLAIM_REQ,
    CLAIM_RSP,
    DISPATCH,
    WAIT_DONE,
    COMPL_REQ,
    COOLDOWN
  } state_e;

  localparam logic [31:0] ClaimOffset = 32'h0020_0004;

  // ID 0 means "nothing pending"; IDs beyond the source count cannot be real.
  function automatic logic is_spurious(input logic [31:0] id, input logic [31:0] num_src);
    return (id == 32'd0) || (id > num_src);
  endfunction

endpackage

// File: rtl/plic_agent_timer.sv
// Loadable down-counter; expire is high while the count sits at zero.
module plic_agent_timer #(
  parameter int W = 11
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         enable,
  output logic         expire
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expire = (count_reg == '0);

endmodule

// File: rtl/plic_claim_agent.sv
// Hardware PLIC claim agent: claims an interrupt, dispatches it to a handler,
// waits for done (or a timeout) and writes the completion back.
module plic_claim_agent
  import plic_agent_pkg::*;
#(
  parameter int          NumSrc      = 32,
  parameter int          IdW         = $clog2(NumSrc) + 1,
  parameter logic [31:0] BaseAddr    = 32'h0,
  parameter int          CooldownCyc = 3,
  parameter int          TimeoutCyc  = 1024
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           enable_i,
  input  logic           irq_external_i,
  output logic           reg_en_o,
  output logic           reg_we_o,
  output logic [31:0]    reg_addr_o,
  output logic [31:0]    reg_wdata_o,
  input  logic [31:0]    reg_rdata_i,
  input  logic           reg_ready_i,
  output logic           evt_valid_o,
  output logic [IdW-1:0] evt_id_o,
  input  logic           evt_ready_i,
  input  logic           done_valid_i,
  input  logic [IdW-1:0] done_id_i,
  output logic           busy_o,
  output logic           timeout_o,
  output logic           mismatch_o,
  output logic [15:0]    spurious_cnt_o,
  input  logic           clr_err_i
);

  localparam int TmrMax = (TimeoutCyc > CooldownCyc) ? TimeoutCyc : CooldownCyc;
  localparam int TmrW   = $clog2(TmrMax + 1);

  state_e            state_reg, state_next;
  logic [IdW-1:0]    id_reg, id_next;
  logic [IdW-1:0]    rsp_id;
  logic              rdata_unused;

  logic              reg_en_reg, reg_we_reg, evt_valid_reg, busy_reg;
  logic [31:0]       reg_addr_reg, reg_wdata_reg;
  logic [IdW-1:0]    evt_id_reg;
  logic              timeout_reg, mismatch_reg, mismatch_next;
  logic [15:0]       spur_cnt_reg;

  logic              tmr_load, tmr_en, tmr_expire;
  logic [TmrW-1:0]   tmr_load_val;
  logic              spur_inc, timeout_set;
  logic              access_next;

  assign rsp_id       = reg_rdata_i[IdW-1:0];
  assign rdata_unused = ^reg_rdata_i[31:IdW];

  plic_agent_timer #(.W(TmrW)) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .enable   (tmr_en),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_next    = state_reg;
    id_next       = id_reg;
    tmr_load      = 1'b0;
    tmr_load_val  = '0;
    tmr_en        = 1'b0;
    spur_inc      = 1'b0;
    timeout_set   = 1'b0;
    mismatch_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable_i && irq_external_i) state_next = CLAIM_REQ;
      end
      CLAIM_REQ: begin
        if (reg_ready_i) state_next = CLAIM_RSP;
      end
      CLAIM_RSP: begin
        id_next = rsp_id;
        if (is_spurious(32'(rsp_id), 32'(NumSrc))) begin
          spur_inc     = 1'b1;
          state_next   = COOLDOWN;
          tmr_load     = 1'b1;
          tmr_load_val = TmrW'(CooldownCyc - 1);
        end else begin
          state_next = DISPATCH;
        end
      end
      DISPATCH: begin
        if (evt_ready_i) begin
          state_next   = WAIT_DONE;
          tmr_load     = 1'b1;
          tmr_load_val = TmrW'(TimeoutCyc - 1);
        end
      end
      WAIT_DONE: begin
        tmr_en = 1'b1;
        // A matching done beats a simultaneous timeout expiry.
        if (done_valid_i && (done_id_i == id_reg)) begin
          state_next = COMPL_REQ;
        end else begin
          mismatch_next = done_valid_i;
          if (tmr_expire) begin
            timeout_set = 1'b1;
            state_next  = COMPL_REQ;
          end
        end
      end
      COMPL_REQ: begin
        if (reg_ready_i) begin
          state_next   = COOLDOWN;
          tmr_load     = 1'b1;
          tmr_load_val = TmrW'(CooldownCyc - 1);
        end
      end
      COOLDOWN: begin
        tmr_en = 1'b1;
        if (tmr_expire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign access_next = (state_next == CLAIM_REQ) || (state_next == COMPL_REQ);

  // Outputs are decoded from the next state so they leave a flop directly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      id_reg        <= '0;
      reg_en_reg    <= 1'b0;
      reg_we_reg    <= 1'b0;
      reg_addr_reg  <= '0;
      reg_wdata_reg <= '0;
      evt_valid_reg <= 1'b0;
      evt_id_reg    <= '0;
      busy_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
      mismatch_reg  <= 1'b0;
      spur_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      id_reg        <= id_next;
      reg_en_reg    <= access_next;
      reg_we_reg    <= (state_next == COMPL_REQ);
      reg_addr_reg  <= access_next ? (BaseAddr + ClaimOffset) : 32'h0;
      reg_wdata_reg <= (state_next == COMPL_REQ) ? 32'(id_next) : 32'h0;
      evt_valid_reg <= (state_next == DISPATCH);
      evt_id_reg    <= (state_next == DISPATCH) ? id_next : '0;
      busy_reg      <= (state_next != IDLE);
      mismatch_reg  <= mismatch_next;
      if (clr_err_i) begin
        timeout_reg  <= 1'b0;
        spur_cnt_reg <= '0;
      end else begin
        if (timeout_set) timeout_reg <= 1'b1;
        if (spur_inc && (spur_cnt_reg != 16'hFFFF)) spur_cnt_reg <= spur_cnt_reg + 16'd1;
      end
    end
  end

  assign reg_en_o       = reg_en_reg;
  assign reg_we_o       = reg_we_reg;
  assign reg_addr_o     = reg_addr_reg;
  assign reg_wdata_o    = reg_wdata_reg;
  assign evt_valid_o    = evt_valid_reg;
  assign evt_id_o       = evt_id_reg;
  assign busy_o         = busy_reg;
  assign timeout_o      = timeout_reg;
  assign mismatch_o     = mismatch_reg;
  assign spurious_cnt_o = spur_cnt_reg;

endmodule
